pwl_sign_restore: RTL and testbench
===================================

// Module: pwl_sign_restore
// PURPOSE
//  Output-side partner of the fixed-point absolute stage: PWL sigmoid/tanh cores evaluate f(|x|);
//  this block re-applies input symmetry to the core's magnitude result. It captures sign(x) and
//  function select per accepted input in an order-preserving FIFO. As each core result returns,
//  it pops the matching entry and emits signed y through a registered valid/ready output stage.
// PARAMETERS
//  DATA_WIDTH  16  width of x, core magnitude and y (two's complement fixed point)
//  FRAC_BITS   12  fractional bits; ONE = 1<<FRAC_BITS; legal range FRAC_BITS <= DATA_WIDTH-2
//  DEPTH       4   sign FIFO entries (>= core pipeline depth); power of two
// PORTS
//  CLK            in   1           clock, rising edge
//  RST            in   1           asynchronous, active-low reset
//  in_valid       in   1           input x offered (same beat the core is fed)
//  in_ready       out  1           = !fifo_full
//  in_x           in   DATA_WIDTH  signed input; only MSB is stored
//  in_func        in   1           0 = tanh (odd symmetry), 1 = sigmoid (1-f symmetry)
//  core_valid     in   1           core magnitude result available
//  core_ready     out  1           = !fifo_empty && (!out_valid || out_ready)
//  core_mag       in   DATA_WIDTH  unsigned f(|x|), Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS
//  out_valid      out  1           y valid
//  out_ready      in   1           downstream accepts y
//  out_y          out  DATA_WIDTH  signed result
//  sign_underflow out  1           sticky: core_valid seen while FIFO empty
// BEHAVIOUR
//  Reset (RST low, async): FIFO empty (rd/wr ptr, count = 0), out_valid=0, out_y=0,
//   sign_underflow=0; in_ready=1 and core_ready=0 as combinational results of the empty FIFO.
//  Push: in_valid && in_ready -> write {in_x[MSB], in_func}; x==0 stores sign 0.
//  Pop: core_valid && core_ready -> read head entry {s, f}; load out_y, set out_valid next edge.
//  Latency: core beat accepted at edge N -> out_valid=1 after edge N; 1 cycle.
//  Simultaneous push+pop: count unchanged, both take effect; when full, push is refused that
//   cycle (no bypass), in_ready rises the cycle after the pop.
//  Pointers wrap modulo DEPTH; count in 0..DEPTH; full = (count==DEPTH).
//  Output stage: out_valid && !out_ready -> out_y, out_valid held; core_ready low (no pop).
//   out_valid && out_ready with no new pop -> out_valid clears next edge.
//   out_ready && new pop same cycle -> back-to-back, out_valid stays 1, out_y updates.
//  Arithmetic: m = (core_mag > ONE) ? ONE : core_mag (saturate).
//   f=0 tanh:    y = s ? -m (two's complement, DATA_WIDTH bits) : m
//   f=1 sigmoid: y = s ? ONE - m : m   (m < ONE/2 is accepted as is, no error)
//   no intermediate exceeds DATA_WIDTH+1 bits; truncate to DATA_WIDTH after saturation.
//  Underflow: core_valid && fifo_empty -> beat not taken (core_ready=0), sign_underflow<=1,
//   held until reset.
//  Reset mid-operation: pending FIFO entries and a held out_y are discarded, no output emitted.
// TESTING  (DATA_WIDTH=16, FRAC_BITS=12, ONE=0x1000, DEPTH=4)
//  tanh: push in_x=0xF000 f=0; core_mag=0x0C30 -> out_y=0xF3D0 one cycle later; push
//   in_x=0x0800, core_mag=0x0761 -> out_y=0x0761.
//  sigmoid: push x<0, core_mag=0x0E00 -> out_y=0x0200; push x>0, core_mag=0x0E00 -> 0x0E00;
//   push x=0x0000 -> sign 0, out_y = core_mag.
//  saturation: tanh s=1 core_mag=0x1200 -> out_y=0xF000; sigmoid s=1 core_mag=0x1200 -> 0x0000.
//  FIFO: 4 pushes signs 1,0,1,1 -> in_ready=0, 5th held; pop+push same cycle refused, in_ready=1
//   next cycle; outputs carry signs in order 1,0,1,1 with ptr wrap after 8 total pushes.
//  backpressure: out_ready=0 for 3 cycles with core_valid=1 -> out_y stable, core_ready=0,
//   count unchanged; out_ready=1 -> back-to-back results, no beat lost or duplicated.
//  underflow + reset: core_valid with empty FIFO -> core_ready=0, sign_underflow=1 sticky;
//   2 entries pending then RST low -> out_valid=0, count=0, in_ready=1, sign_underflow=0.

Source files
------------

// File: rtl/pwl_sign_restore.sv
// Re-applies input symmetry (tanh odd / sigmoid 1-f) to PWL core magnitudes via an order-preserving sign FIFO.
// One-cycle registered output; core_ready drops while the output is held or the FIFO is empty.
module pwl_sign_restore #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 12,
  parameter int DEPTH      = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_x,
  input  logic                  in_func,
  input  logic                  core_valid,
  output logic                  core_ready,
  input  logic [DATA_WIDTH-1:0] core_mag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_y,
  output logic                  sign_underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << FRAC_BITS;

  // Each entry is {sign, func}.
  logic [1:0]            mem_q [DEPTH];
  logic [1:0]            mem_d [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_y_q, out_y_d;
  logic                  sign_underflow_q, sign_underflow_d;

  logic                  fifo_full, fifo_empty;
  logic                  push, pop;
  logic [1:0]            head;
  logic [DATA_WIDTH-1:0] sat_mag;
  logic [DATA_WIDTH-1:0] y_val;
  logic                  unused_x;

  assign unused_x   = ^in_x[DATA_WIDTH-2:0];
  assign fifo_full  = (count_q == DEPTH_C);
  assign fifo_empty = (count_q == '0);
  assign in_ready   = !fifo_full;
  assign core_ready = !fifo_empty && (!out_valid_q || out_ready);
  assign push       = in_valid && in_ready;
  assign pop        = core_valid && core_ready;
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    sat_mag = (core_mag > ONE) ? ONE : core_mag;
    y_val   = sat_mag;
    case (head)
      2'b10:   y_val = -sat_mag;
      2'b11:   y_val = ONE - sat_mag;
      default: y_val = sat_mag;
    endcase
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {in_x[DATA_WIDTH-1], in_func};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_comb begin
    out_valid_d      = out_valid_q;
    out_y_d          = out_y_q;
    sign_underflow_d = sign_underflow_q | (core_valid && fifo_empty);
    if (pop) begin
      out_valid_d = 1'b1;
      out_y_d     = y_val;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 2'b00;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      out_valid_q      <= 1'b0;
      out_y_q          <= '0;
      sign_underflow_q <= 1'b0;
    end else begin
      mem_q            <= mem_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      out_valid_q      <= out_valid_d;
      out_y_q          <= out_y_d;
      sign_underflow_q <= sign_underflow_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_y          = out_y_q;
  assign sign_underflow = sign_underflow_q;

endmodule

// File: tb/tb_pwl_sign_restore.sv
// Directed plus randomized bench for pwl_sign_restore against a queue-based reference model.
module tb_pwl_sign_restore;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x;
  logic        in_func;
  logic        core_valid;
  logic        core_ready;
  logic [15:0] core_mag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_y;
  logic        sign_underflow;

  int checks = 0;
  int errors = 0;

  // Reference state: pending {sign, func} entries and the expected output register.
  bit [1:0]    q[$];
  bit          m_ov;
  logic [15:0] m_y;
  bit          m_uf;

  pwl_sign_restore #(.DATA_WIDTH(16), .FRAC_BITS(12), .DEPTH(4)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_func(in_func),
    .core_valid(core_valid), .core_ready(core_ready), .core_mag(core_mag),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .sign_underflow(sign_underflow)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] ref_y(input bit s, input bit f, input logic [15:0] mag);
    int m;
    int r;
    m = (int'(mag) > 4096) ? 4096 : int'(mag);
    if (!f) r = s ? ((65536 - m) % 65536) : m;
    else    r = s ? (4096 - m) : m;
    return 16'(r);
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered and left just after a rising edge; drives one cycle of stimulus.
  task automatic cycle(input bit iv, input logic [15:0] ix, input bit ifn,
                       input bit cv, input logic [15:0] cm, input bit ordy);
    bit       exp_ir;
    bit       exp_cr;
    bit [1:0] e;
    in_valid   = iv;
    in_x       = ix;
    in_func    = ifn;
    core_valid = cv;
    core_mag   = cm;
    out_ready  = ordy;
    #3;
    exp_ir = (q.size() < 4);
    exp_cr = (q.size() > 0) && (!m_ov || ordy);
    chk1("in_ready", in_ready, exp_ir);
    chk1("core_ready", core_ready, exp_cr);
    chk1("out_valid", out_valid, m_ov);
    chk16("out_y", out_y, m_y);
    chk1("sign_underflow", sign_underflow, m_uf);
    if (cv && q.size() == 0) m_uf = 1'b1;
    if (cv && exp_cr) begin
      e    = q.pop_front();
      m_y  = ref_y(e[1], e[0], cm);
      m_ov = 1'b1;
    end else if (ordy) begin
      m_ov = 1'b0;
    end
    if (iv && exp_ir) q.push_back({ix[15], ifn});
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
  endtask

  initial begin
    RST = 1'b0; in_valid = 0; in_x = 0; in_func = 0;
    core_valid = 0; core_mag = 0; out_ready = 1;
    m_ov = 0; m_y = 16'h0000; m_uf = 0;
    @(posedge CLK); @(posedge CLK); #1;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk16("rst_out_y", out_y, 16'h0000);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_core_ready", core_ready, 1'b0);
    chk1("rst_underflow", sign_underflow, 1'b0);
    RST = 1'b1;
    @(posedge CLK); #1;

    // tanh
    cycle(1, 16'hF000, 0, 0, 16'h0000, 1);
    cycle(0, 16'h0000, 0, 1, 16'h0C30, 1);
    chk1("tanh_neg_vld", out_valid, 1'b1);
    chk16("tanh_neg", out_y, 16'hF3D0);
    cycle(1, 16'h0800, 0, 0, 16'h0000, 1);
    cycle(0, 16'h0000, 0, 1, 16'h0761, 1);
    chk16("tanh_pos", out_y, 16'h0761);
    idle();
    chk1("out_valid_clear", out_valid, 1'b0);

    // sigmoid
    cycle(1, 16'h9000, 1, 0, 16'h0000, 1);
    cycle(1, 16'h0400, 1, 1, 16'h0E00, 1);
    chk16("sig_neg", out_y, 16'h0200);
    cycle(1, 16'h0000, 1, 1, 16'h0E00, 1);
    chk16("sig_pos", out_y, 16'h0E00);
    cycle(0, 16'h0000, 0, 1, 16'h0A00, 1);
    chk16("sig_zero", out_y, 16'h0A00);

    // saturation
    cycle(1, 16'h8000, 0, 0, 16'h0000, 1);
    cycle(1, 16'hC000, 1, 1, 16'h1200, 1);
    chk16("sat_tanh", out_y, 16'hF000);
    cycle(0, 16'h0000, 0, 1, 16'h1200, 1);
    chk16("sat_sig", out_y, 16'h0000);
    idle();

    // FIFO full, refused push during pop, order preserved
    cycle(1, 16'h8000, 0, 0, 16'h0000, 1);
    cycle(1, 16'h0100, 0, 0, 16'h0000, 1);
    cycle(1, 16'hFFFF, 0, 0, 16'h0000, 1);
    cycle(1, 16'h8001, 0, 0, 16'h0000, 1);
    chk1("full_in_ready", in_ready, 1'b0);
    cycle(1, 16'h0200, 0, 1, 16'h0300, 1);
    chk16("fifo_o1", out_y, 16'hFD00);
    chk1("in_ready_after_pop", in_ready, 1'b1);
    cycle(1, 16'h0200, 0, 1, 16'h0300, 1);
    chk16("fifo_o2", out_y, 16'h0300);
    cycle(0, 16'h0000, 0, 1, 16'h0300, 1);
    chk16("fifo_o3", out_y, 16'hFD00);
    cycle(0, 16'h0000, 0, 1, 16'h0300, 1);
    chk16("fifo_o4", out_y, 16'hFD00);
    cycle(0, 16'h0000, 0, 1, 16'h0300, 1);
    chk16("fifo_o5", out_y, 16'h0300);
    idle();

    // backpressure: hold for 3 cycles, then drain back-to-back
    cycle(1, 16'h8000, 0, 0, 16'h0000, 1);
    cycle(1, 16'h0100, 1, 0, 16'h0000, 1);
    cycle(1, 16'hA000, 1, 1, 16'h0123, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 16'h0000, 0, 1, 16'h0456, 0);
      chk16("bp_hold", out_y, 16'hFEDD);
    end
    cycle(0, 16'h0000, 0, 1, 16'h0456, 1);
    chk16("bp_b2b1", out_y, 16'h0456);
    cycle(0, 16'h0000, 0, 1, 16'h0F00, 1);
    chk16("bp_b2b2", out_y, 16'h0100);
    idle();
    idle();

    // underflow, sticky
    cycle(0, 16'h0000, 0, 1, 16'h0555, 1);
    idle();
    chk1("uf_sticky", sign_underflow, 1'b1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(bit'($urandom_range(0, 1)), 16'($urandom), bit'($urandom_range(0, 1)),
            bit'($urandom_range(0, 1)), 16'($urandom_range(0, 16'h1400)),
            ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 6; i++) cycle(0, 16'h0000, 0, 1, 16'h0777, 1);
    idle();

    // reset mid-operation with two entries pending and a held output
    cycle(1, 16'h8000, 0, 0, 16'h0000, 1);
    cycle(1, 16'h1234, 1, 0, 16'h0000, 1);
    cycle(1, 16'hF234, 1, 1, 16'h0800, 0);
    chk1("pre_rst_vld", out_valid, 1'b1);
    in_valid = 0; core_valid = 1; core_mag = 16'h0100; out_ready = 0;
    #2;
    RST = 1'b0;
    #1;
    chk1("mid_rst_out_valid", out_valid, 1'b0);
    chk16("mid_rst_out_y", out_y, 16'h0000);
    chk1("mid_rst_in_ready", in_ready, 1'b1);
    chk1("mid_rst_core_ready", core_ready, 1'b0);
    chk1("mid_rst_underflow", sign_underflow, 1'b0);
    q.delete(); m_ov = 0; m_y = 16'h0000; m_uf = 0;
    @(posedge CLK); #1;
    RST = 1'b1;
    idle();
    cycle(0, 16'h0000, 0, 1, 16'h0100, 1);
    idle();
    chk1("post_rst_no_out", out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
